freq_lock_detect: RTL and testbench

- Digital frequency-lock detector that sits directly downstream of the PLL feedback divider.
- Consumes the divided feedback clock F_PFD and the reference clock F_ref, both oversampled by the fast clock Fin.
- Counts feedback edges over a fixed window of reference periods and reports the signed frequency error, fast/slow flags and a qualified Lock flag.
- Any change of the divider select Fsel invalidates lock and restarts measurement.

---
 rtl/pll_pkg.sv | 15 +
 rtl/freq_lock_detect_edge_sync.sv | 28 ++
 rtl/freq_lock_detect.sv | 168 ++++++++++++++++
 tb/tb_freq_lock_detect.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL frequency-lock detector.
// Pure declarations: no logic, no latency, no flow control.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    COMPARE = 2'd2
  } state_t;

  localparam int WIN_LOG2_DEF = 4;
  localparam int CW_DEF       = 8;
  localparam int FSEL_W       = 4;

endpackage

// File: rtl/freq_lock_detect_edge_sync.sv
// Two-flop synchroniser plus edge flop producing a one-cycle rising-edge pulse.
// Pulse is consumed 3 sampling-clock edges after the input edge; no backpressure.
module edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/freq_lock_detect.sv
// Counts feedback edges over 2^WIN_LOG2 reference periods; reports signed error, fast/slow, lock.
// Results update one cycle after the closing reference edge (Valid pulse); no backpressure.
module freq_lock_detect
  import pll_pkg::*;
#(
  parameter int WIN_LOG2     = WIN_LOG2_DEF,
  parameter int CW           = CW_DEF,
  parameter int TOL          = 1,
  parameter int LOCK_WINDOWS = 3
) (
  input  logic              Fin,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              F_ref,
  input  logic              F_PFD,
  input  logic [FSEL_W-1:0] Fsel,
  output logic [CW:0]       Err,
  output logic              Valid,
  output logic              Fast,
  output logic              Slow,
  output logic              Lock
);

  localparam int RW = WIN_LOG2 + 1;
  localparam int LW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [RW-1:0]      REF_LAST  = RW'((2 ** WIN_LOG2) - 1);
  localparam logic [CW:0]        WIN_EDGES = (CW + 1)'(2 ** WIN_LOG2);
  localparam logic [CW-1:0]      PFD_MAX   = {CW{1'b1}};
  localparam logic [LW-1:0]      LOCK_MAX  = LW'(LOCK_WINDOWS);
  localparam logic signed [CW:0] TOL_S     = (CW + 1)'(TOL);

  state_t            r_state;
  logic [RW-1:0]     r_ref_cnt;
  logic [CW-1:0]     r_pfd_cnt;
  logic [LW-1:0]     r_lock_cnt;
  logic [CW:0]       r_err;
  logic              r_valid;
  logic              r_fast;
  logic              r_slow;
  logic              r_lock;
  logic [FSEL_W-1:0] r_fsel_q;

  state_t            w_state_nxt;
  logic [RW-1:0]     w_ref_nxt;
  logic [CW-1:0]     w_pfd_nxt;
  logic [CW-1:0]     w_pfd_inc;
  logic [LW-1:0]     w_lock_cnt_nxt;
  logic [CW:0]       w_err_nxt;
  logic              w_valid_nxt;
  logic              w_fast_nxt;
  logic              w_slow_nxt;
  logic              w_lock_nxt;
  logic              w_ref_e;
  logic              w_pfd_e;
  logic              w_fsel_chg;
  logic              w_abort;
  logic              w_in_tol;
  logic signed [CW:0] w_err;

  edge_sync u_ref_sync (
    .i_clk  (Fin),
    .i_rst  (Reset),
    .i_d    (F_ref),
    .o_rise (w_ref_e)
  );

  edge_sync u_pfd_sync (
    .i_clk  (Fin),
    .i_rst  (Reset),
    .i_d    (F_PFD),
    .o_rise (w_pfd_e)
  );

  assign w_fsel_chg = (Fsel != r_fsel_q);
  assign w_abort    = ~Enable | w_fsel_chg;
  // Zero-extend before subtracting so a saturated count never reads as negative.
  assign w_err      = {1'b0, r_pfd_cnt} - WIN_EDGES;
  assign w_in_tol   = (w_err <= TOL_S) && (w_err >= -TOL_S);
  assign w_pfd_inc  = (r_pfd_cnt == PFD_MAX) ? PFD_MAX : r_pfd_cnt + CW'(w_pfd_e);

  always_comb begin
    w_state_nxt    = r_state;
    w_ref_nxt      = r_ref_cnt;
    w_pfd_nxt      = r_pfd_cnt;
    w_lock_cnt_nxt = r_lock_cnt;
    w_err_nxt      = r_err;
    w_valid_nxt    = 1'b0;
    w_fast_nxt     = r_fast;
    w_slow_nxt     = r_slow;
    w_lock_nxt     = r_lock;

    if (w_abort) begin
      w_state_nxt    = IDLE;
      w_ref_nxt      = '0;
      w_pfd_nxt      = '0;
      w_lock_cnt_nxt = '0;
      w_lock_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_ref_nxt = '0;
          w_pfd_nxt = '0;
          if (w_ref_e) w_state_nxt = MEASURE;
        end
        MEASURE: begin
          w_ref_nxt = r_ref_cnt + RW'(w_ref_e);
          w_pfd_nxt = w_pfd_inc;
          if (w_ref_e && (r_ref_cnt == REF_LAST)) w_state_nxt = COMPARE;
        end
        COMPARE: begin
          w_err_nxt   = w_err;
          w_fast_nxt  = (w_err > TOL_S);
          w_slow_nxt  = (w_err < -TOL_S);
          w_valid_nxt = 1'b1;
          if (w_in_tol) begin
            w_lock_cnt_nxt = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + LW'(1);
            w_lock_nxt     = (w_lock_cnt_nxt == LOCK_MAX);
          end else begin
            w_lock_cnt_nxt = '0;
            w_lock_nxt     = 1'b0;
          end
          // Edges landing in this cycle open the next window.
          w_ref_nxt   = RW'(w_ref_e);
          w_pfd_nxt   = CW'(w_pfd_e);
          w_state_nxt = MEASURE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_ref_nxt   = '0;
          w_pfd_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Fin) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_ref_cnt  <= '0;
      r_pfd_cnt  <= '0;
      r_lock_cnt <= '0;
      r_err      <= '0;
      r_valid    <= 1'b0;
      r_fast     <= 1'b0;
      r_slow     <= 1'b0;
      r_lock     <= 1'b0;
      r_fsel_q   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ref_cnt  <= w_ref_nxt;
      r_pfd_cnt  <= w_pfd_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_err      <= w_err_nxt;
      r_valid    <= w_valid_nxt;
      r_fast     <= w_fast_nxt;
      r_slow     <= w_slow_nxt;
      r_lock     <= w_lock_nxt;
      r_fsel_q   <= Fsel;
    end
  end

  assign Err   = r_err;
  assign Valid = r_valid;
  assign Fast  = r_fast;
  assign Slow  = r_slow;
  assign Lock  = r_lock;

endmodule

// File: tb/tb_freq_lock_detect.sv
// Scoreboard bench for freq_lock_detect: CW=8 and CW=6 instances share one stimulus stream.
module tb_freq_lock_detect;
  import pll_pkg::*;

  localparam int EV_NONE = 0;
  localparam int EV_FSEL = 1;
  localparam int EV_EN   = 2;
  localparam int EV_RST  = 3;
  localparam int EV_OFF  = 4;

  logic       Fin = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       F_ref;
  logic       F_PFD;
  logic [3:0] Fsel;

  logic [8:0] err8;
  logic       v8, f8, s8, l8;
  logic [6:0] err6;
  logic       v6, f6, s6, l6;

  freq_lock_detect #(.WIN_LOG2(4), .CW(8), .TOL(1), .LOCK_WINDOWS(3)) u_dut8 (
    .Fin(Fin), .Reset(Reset), .Enable(Enable), .F_ref(F_ref), .F_PFD(F_PFD), .Fsel(Fsel),
    .Err(err8), .Valid(v8), .Fast(f8), .Slow(s8), .Lock(l8)
  );

  freq_lock_detect #(.WIN_LOG2(4), .CW(6), .TOL(1), .LOCK_WINDOWS(3)) u_dut6 (
    .Fin(Fin), .Reset(Reset), .Enable(Enable), .F_ref(F_ref), .F_PFD(F_PFD), .Fsel(Fsel),
    .Err(err6), .Valid(v6), .Fast(f6), .Slow(s6), .Lock(l6)
  );

  initial forever #5 Fin = ~Fin;

  typedef struct {
    int err8;
    int err6;
    bit fast8;
    bit fast6;
    bit slow;
    bit lock;
  } exp_t;

  typedef struct {
    string name;
    bit    is_end;
    int    err;
    bit    fast;
    bit    slow;
    bit    lock;
  } probe_t;

  exp_t   q8[$];
  exp_t   q6[$];
  probe_t pq[$];

  int     n_checks = 0;
  int     n_errors = 0;
  int     n_win8 = 0;
  int     n_win6 = 0;
  exp_t   m_e;
  probe_t m_p;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: pops one expectation per Valid, and services point-in-time probes.
  always @(negedge Fin) begin
    if (v8) begin
      n_win8++;
      if (q8.size() == 0) begin
        chk("valid8_unexpected", 1, 0);
      end else begin
        m_e = q8.pop_front();
        chk($sformatf("w%0d.err8", n_win8), int'($signed(err8)), m_e.err8);
        chk($sformatf("w%0d.fast8", n_win8), int'(f8), int'(m_e.fast8));
        chk($sformatf("w%0d.slow8", n_win8), int'(s8), int'(m_e.slow));
        chk($sformatf("w%0d.lock8", n_win8), int'(l8), int'(m_e.lock));
      end
    end
    if (v6) begin
      n_win6++;
      if (q6.size() == 0) begin
        chk("valid6_unexpected", 1, 0);
      end else begin
        m_e = q6.pop_front();
        chk($sformatf("w%0d.err6", n_win6), int'($signed(err6)), m_e.err6);
        chk($sformatf("w%0d.fast6", n_win6), int'(f6), int'(m_e.fast6));
        chk($sformatf("w%0d.slow6", n_win6), int'(s6), int'(m_e.slow));
        chk($sformatf("w%0d.lock6", n_win6), int'(l6), int'(m_e.lock));
      end
    end
    while (pq.size() > 0) begin
      m_p = pq.pop_front();
      if (m_p.is_end) begin
        chk("pending8", q8.size(), 0);
        chk("pending6", q6.size(), 0);
      end else begin
        chk({m_p.name, ".valid8"}, int'(v8), 0);
        chk({m_p.name, ".err8"}, int'($signed(err8)), m_p.err);
        chk({m_p.name, ".fast8"}, int'(f8), int'(m_p.fast));
        chk({m_p.name, ".slow8"}, int'(s8), int'(m_p.slow));
        chk({m_p.name, ".lock8"}, int'(l8), int'(m_p.lock));
        chk({m_p.name, ".valid6"}, int'(v6), 0);
        chk({m_p.name, ".err6"}, int'($signed(err6)), m_p.err);
        chk({m_p.name, ".lock6"}, int'(l6), int'(m_p.lock));
      end
    end
  end

  task automatic step();
    @(posedge Fin);
    #1;
  endtask

  task automatic probe(input string nm, input int e, input bit f, input bit s, input bit l);
    probe_t p;
    p.name   = nm;
    p.is_end = 1'b0;
    p.err    = e;
    p.fast   = f;
    p.slow   = s;
    p.lock   = l;
    pq.push_back(p);
  endtask

  // One window's worth of stimulus: ref period 32 Fin cycles rising at local cycle 0,
  // feedback rising at 8, 8+p, ... below 512. The window opened by this call closes
  // on the next call's first ref edge, so the expectation is pushed here.
  task automatic do_call(input int p, input int ev, input bit has, input int e8, input int e6,
                         input bit fa8, input bit fa6, input bit sl, input bit lk);
    exp_t e;
    bit   ref_off;
    ref_off = 1'b0;
    if (has) begin
      e.err8 = e8; e.err6 = e6; e.fast8 = fa8; e.fast6 = fa6; e.slow = sl; e.lock = lk;
      q8.push_back(e);
      q6.push_back(e);
    end
    for (int l = 0; l < 512; l++) begin
      step();
      F_ref = !ref_off && ((l % 32) < 16);
      F_PFD = (l >= 8) && (((l - 8) % p) < (p / 2));
      if (ev != EV_NONE && l == 200) begin
        case (ev)
          EV_FSEL: begin probe("fsel_pre", 0, 0, 0, 1); Fsel = 4'b0101; end
          EV_EN:   begin probe("en_pre", 0, 0, 0, 1); Enable = 1'b0; end
          EV_RST:  begin probe("rst_pre", -3, 0, 1, 0); Reset = 1'b1; end
          default: Enable = 1'b0;
        endcase
        // Park the reference low so the restart aligns with the next call.
        ref_off = 1'b1;
      end
      if (l == 201 && ev == EV_EN) Enable = 1'b1;
      if (l == 201 && ev == EV_RST) begin
        Reset = 1'b0;
        probe("rst_post", 0, 0, 0, 0);
      end
      if (l == 202 && ev == EV_FSEL) probe("fsel_post", 0, 0, 0, 0);
      if (l == 202 && ev == EV_EN) probe("en_post", 0, 0, 0, 0);
    end
  endtask

  initial begin
    probe_t pe;
    Reset  = 1'b1;
    Enable = 1'b0;
    Fsel   = 4'b0001;
    F_ref  = 1'b0;
    F_PFD  = 1'b0;
    repeat (3) step();
    probe("reset", 0, 0, 0, 0);
    step();
    Reset  = 1'b0;
    Enable = 1'b1;
    repeat (8) step();

    //       p   event    has  e8   e6  f8 f6 sl lk
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 1);
    do_call(28, EV_NONE, 1,   2,   2,  1, 1, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(30, EV_NONE, 1,   1,   1,  0, 0, 0, 0);
    do_call(30, EV_NONE, 1,   1,   1,  0, 0, 0, 1);
    do_call(30, EV_NONE, 1,   1,   1,  0, 0, 0, 1);
    do_call(40, EV_NONE, 1,  -3,  -3,  0, 0, 1, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 1);
    do_call(32, EV_FSEL, 0,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 1);
    do_call(32, EV_EN,   0,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(40, EV_NONE, 1,  -3,  -3,  0, 0, 1, 0);
    do_call(32, EV_RST,  0,   0,   0,  0, 0, 0, 0);
    do_call( 4, EV_NONE, 1, 110,  47,  1, 1, 0, 0);
    do_call(32, EV_NONE, 1,   0,   0,  0, 0, 0, 0);
    do_call(32, EV_OFF,  0,   0,   0,  0, 0, 0, 0);

    repeat (20) step();
    pe.name   = "end";
    pe.is_end = 1'b1;
    pe.err    = 0;
    pe.fast   = 1'b0;
    pe.slow   = 1'b0;
    pe.lock   = 1'b0;
    pq.push_back(pe);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
